// File: rtl/uart_pkg.sv
// Shared UART framing encodings, FSM state type and small framing helpers,
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [1:0] STOP_1   = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;
  localparam logic       PAR_EVEN = 1'b0;
  localparam logic       PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // 00 behaves like one stop bit, 11 like two.
  function automatic logic two_stop(input logic [1:0] sb);
    return (sb == STOP_2) || (sb == (STOP_1 | STOP_2));
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ (odd != PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Phase-accumulator bit-rate generator: adds baudrate every enabled clock and
// emits bit_tick each time the accumulator wraps past CLK_FREQ.
module uart_baud_gen #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [BAUD_W-1:0] baudrate,
  output logic              bit_tick
);

  // One extra bit so acc + baudrate never overflows (acc < CLK_FREQ, baudrate <= CLK_FREQ/2).
  localparam logic [BAUD_W:0] CLK_F = (BAUD_W + 1)'(CLK_FREQ);

  logic [BAUD_W:0] acc;
  logic [BAUD_W:0] sum;

  assign sum      = acc + {1'b0, baudrate};
  assign bit_tick = en && (sum >= CLK_F);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= bit_tick ? (sum - CLK_F) : sum;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start,
// 8 data bits LSB first, optional parity and 1 or 2 stop bits.
//
// state  | meaning
// IDLE   | line high, ready when baudrate is usable
// START  | start bit (low)
// DATA   | data bit idx on the line
// PARITY | parity bit on the line
// STOP   | stop bit(s) high, stop_cnt counts periods
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baudrate,
  input  logic              valid,
  input  logic [7:0]        tx_data,
  input  logic [1:0]        stop_bits,
  input  logic              parity_en,
  input  logic              parity_type,
  output logic              ready,
  output logic              busy,
  output logic              tx_done,
  output logic              tx
);

  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_FREQ / 2);

  uart_state_t       state;
  uart_state_t       state_nxt;
  logic [7:0]        data_q;
  logic [BAUD_W-1:0] baud_q;
  logic              two_stop_q;
  logic              par_en_q;
  logic              par_odd_q;
  logic [2:0]        idx;
  logic [2:0]        idx_nxt;
  logic [2:0]        idx_inc;
  logic              stop_cnt;
  logic              stop_cnt_nxt;
  logic              tx_nxt;
  logic              accept;
  logic              bit_tick;
  logic              baud_ok;

  assign baud_ok = (baudrate != '0) && (baudrate <= BAUD_MAX);
  assign ready   = (state == IDLE) && baud_ok;
  assign busy    = (state != IDLE);
  assign idx_inc = idx + 3'd1;

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_W   (BAUD_W)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (busy),
    .baudrate (baud_q),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      data_q     <= '0;
      baud_q     <= '0;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx       <= tx_nxt;
      if (accept) begin
        data_q     <= tx_data;
        baud_q     <= baudrate;
        two_stop_q <= two_stop(stop_bits);
        par_en_q   <= parity_en;
        par_odd_q  <= parity_type;
      end
    end
  end

  // tx_nxt is the value the line takes in the state being entered, so the
  // line flop changes on the same edge as the state register.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = tx;
    tx_done      = 1'b0;
    accept       = 1'b0;
    unique case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (valid && ready) begin
          accept    = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt = DATA;
          idx_nxt   = '0;
          tx_nxt    = data_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx == 3'd7) begin
            if (par_en_q) begin
              state_nxt = PARITY;
              tx_nxt    = parity_bit(data_q, par_odd_q);
            end else begin
              state_nxt    = STOP;
              stop_cnt_nxt = 1'b0;
              tx_nxt       = 1'b1;
            end
          end else begin
            idx_nxt = idx_inc;
            tx_nxt  = data_q[idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_nxt    = STOP;
          stop_cnt_nxt = 1'b0;
          tx_nxt       = 1'b1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_tick) begin
          if (stop_cnt == two_stop_q) begin
            state_nxt = IDLE;
            tx_done   = 1'b1;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: drivers push expected frames, a line monitor
// decodes the serial output cycle by cycle and compares against them.
module tb_uart_tx;

  localparam int  CLK_FREQ = 25000000;
  localparam int  BAUD     = 115200;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_odd;
    bit         two_stop;
    int         baud;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] baudrate;
  logic        valid;
  logic [7:0]  tx_data;
  logic [1:0]  stop_bits;
  logic        parity_en;
  logic        parity_type;
  logic        ready;
  logic        busy;
  logic        tx_done;
  logic        tx;

  int     total = 0;
  int     bad = 0;
  int     frames_done = 0;
  int     frames_aborted = 0;
  bit     mon_busy = 0;
  frame_t sb[$];

  always #20 clk = ~clk;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .baudrate    (baudrate),
    .valid       (valid),
    .tx_data     (tx_data),
    .stop_bits   (stop_bits),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .ready       (ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx          (tx)
  );

  // Line monitor: a frame starts on the edge after a negedge with valid&&ready.
  initial begin : monitor
    frame_t     f;
    int         nb;
    longint     bnd [0:12];
    logic       bits [0:11];
    int         lastc, m, tx_err, ctl_err, done_err, midk;
    logic [7:0] got;
    logic       par_got;
    bit         aborted;
    forever begin
      @(negedge clk);
      while (!rst && valid && ready) begin
        mon_busy = 1;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: accepted byte %02h with nothing expected", tx_data);
          f.data = tx_data; f.par_en = parity_en; f.par_odd = parity_type;
          f.two_stop = stop_bits[1]; f.baud = int'(baudrate);
        end else begin
          f = sb.pop_front();
        end
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
        nb = 9;
        if (f.par_en) begin bits[nb] = (^f.data) ^ f.par_odd; nb++; end
        bits[nb] = 1'b1; nb++;
        if (f.two_stop) begin bits[nb] = 1'b1; nb++; end
        for (int i = 0; i <= nb; i++)
          bnd[i] = (longint'(i) * CLK_FREQ + f.baud - 1) / f.baud;
        lastc = int'(bnd[nb]);
        m = 0; tx_err = 0; ctl_err = 0; done_err = 0; aborted = 0;
        got = '0; par_got = 1'b0;
        for (int k = 1; k <= lastc; k++) begin
          @(negedge clk);
          if (rst) begin aborted = 1; break; end
          while (longint'(k) > bnd[m+1]) m++;
          if (tx !== bits[m]) tx_err++;
          if (busy !== 1'b1 || ready !== 1'b0) ctl_err++;
          if (tx_done !== (k == lastc)) done_err++;
          midk = int'((bnd[m] + bnd[m+1] + 1) / 2);
          if (k == midk && m >= 1 && m <= 8) got[m-1] = tx;
          if (k == midk && f.par_en && m == 9) par_got = tx;
        end
        if (aborted) begin
          frames_aborted++;
        end else begin
          total++;
          if (tx_err != 0) begin bad++;
            $display("FAIL frame_tx: byte %02h had %0d wrong line cycles, want 0", f.data, tx_err); end
          total++;
          if (ctl_err != 0) begin bad++;
            $display("FAIL frame_ctl: byte %02h had %0d cycles with busy/ready wrong, want 0", f.data, ctl_err); end
          total++;
          if (done_err != 0) begin bad++;
            $display("FAIL frame_done: byte %02h tx_done wrong on %0d cycles, want pulse only at cycle %0d", f.data, done_err, lastc); end
          total++;
          if (got !== f.data) begin bad++;
            $display("FAIL rx_data: got %02h want %02h", got, f.data); end
          if (f.par_en) begin
            total++;
            if (((^got) ^ par_got) !== f.par_odd) begin bad++;
              $display("FAIL parity_valid: byte %02h parity bit %0b, odd=%0b", got, par_got, f.par_odd); end
          end
          @(negedge clk);
          total++;
          if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin bad++;
            $display("FAIL idle_after: tx=%0b busy=%0b ready=%0b, want 1 0 1", tx, busy, ready); end
          frames_done++;
        end
        mon_busy = 0;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input bit pe, input bit po, input logic [1:0] stp,
                      input int baud, input bit hold, output bit ok);
    frame_t f;
    @(posedge clk); #1;
    tx_data = d; parity_en = pe; parity_type = po; stop_bits = stp; baudrate = baud;
    f.data = d; f.par_en = pe; f.par_odd = po; f.two_stop = stp[1]; f.baud = baud;
    sb.push_back(f);
    valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_mon(output bit ok);
    ok = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; baudrate = BAUD; tx_data = '0;
    stop_bits = 2'b01; parity_en = 1'b0; parity_type = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %0b want 1", tx); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", tx_done); end
  endtask

  task automatic test_even_41;
    bit ok;
    int cyc, start_len;
    bit seen_high;
    logic [10:0] seq;
    logic [10:0] want_seq;
    want_seq = 11'b10010000010;
    seq = '0; cyc = 0; start_len = 0; seen_high = 0;
    send(8'h41, 1, 0, 2'b01, BAUD, 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL even41_accept: not accepted, want accept"); end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (!seen_high && tx === 1'b0) start_len++; else seen_high = 1;
      for (int b = 0; b < 11; b++)
        if (cyc == int'((longint'(2*b+1) * CLK_FREQ) / (2 * BAUD)) + 1) seq[b] = tx;
      if (tx_done === 1'b1) break;
    end
    total++; if (seq !== want_seq) begin bad++; $display("FAIL even41_seq: got %011b want %011b (bit10..0)", seq, want_seq); end
    total++; if (start_len < 217 || start_len > 218) begin bad++; $display("FAIL even41_bitlen: start bit %0d clocks, want 217..218", start_len); end
    total++; if (cyc != 2388) begin bad++; $display("FAIL even41_done_time: %0d clocks, want 2388 (95.52 us)", cyc); end
    wait_mon(ok);
    total++; if (!ok) begin bad++; $display("FAIL even41_mon: monitor timeout, want idle"); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int idle;
    frame_t f;
    send(8'h41, 1, 0, 2'b01, BAUD, 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_accept1: not accepted, want accept"); end
    tx_data = 8'h42;
    f.data = 8'h42; f.par_en = 1; f.par_odd = 0; f.two_stop = 0; f.baud = BAUD;
    sb.push_back(f);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL b2b_done1: no tx_done, want pulse"); end
    idle = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx === 1'b0) break;
      idle++;
    end
    @(posedge clk); #1 valid = 1'b0;
    total++; if (idle != 1) begin bad++; $display("FAIL b2b_gap: %0d idle clocks, want 1", idle); end
    wait_mon(ok);
    total++; if (!ok || frames_done != 3) begin bad++; $display("FAIL b2b_frames: ok=%0b frames=%0d, want 1 3", ok, frames_done); end
  endtask

  task automatic test_odd_ff;
    bit ok;
    int cyc;
    send(8'hFF, 1, 1, 2'b10, BAUD, 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL oddff_accept: not accepted, want accept"); end
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (tx_done === 1'b1) break;
    end
    total++; if (cyc != 2605) begin bad++; $display("FAIL oddff_done_time: %0d clocks, want 2605", cyc); end
    wait_mon(ok);
    total++; if (!ok) begin bad++; $display("FAIL oddff_mon: monitor timeout, want idle"); end
  endtask

  task automatic test_nopar_00;
    bit ok;
    int cyc;
    send(8'h00, 0, 0, 2'b00, BAUD, 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL nopar_accept: not accepted, want accept"); end
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (tx_done === 1'b1) break;
    end
    total++; if (cyc != 2171) begin bad++; $display("FAIL nopar_done_time: %0d clocks, want 2171 (10 bits)", cyc); end
    wait_mon(ok);
    total++; if (!ok) begin bad++; $display("FAIL nopar_mon: monitor timeout, want idle"); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int dones, lows;
    send(8'h5A, 1, 0, 2'b01, BAUD, 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_accept: not accepted, want accept"); end
    repeat (1195) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL rstmid_state: tx=%0b ready=%0b busy=%0b, want 1 1 0", tx, ready, busy); end
    dones = 0; lows = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) dones++;
      if (tx !== 1'b1) lows++;
    end
    total++; if (dones != 0 || lows != 0) begin bad++;
      $display("FAIL rstmid_quiet: %0d tx_done pulses, %0d low cycles, want 0 0", dones, lows); end
    total++; if (frames_aborted != 1) begin bad++; $display("FAIL rstmid_abort: %0d aborted frames, want 1", frames_aborted); end
    send(8'h3C, 1, 1, 2'b01, BAUD, 0, ok);
    wait_mon(ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_resend: monitor timeout, want idle"); end
  endtask

  task automatic test_bad_baud;
    bit ok;
    int errs;
    frame_t f;
    @(posedge clk); #1 valid = 1'b0; baudrate = CLK_FREQ / 2 + 1;
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL baud_above_max: ready=%0b want 0", ready); end
    @(posedge clk); #1 baudrate = CLK_FREQ / 2;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL baud_at_max: ready=%0b want 1", ready); end
    @(posedge clk); #1;
    baudrate = 0; tx_data = 8'h81; parity_en = 1'b0; parity_type = 1'b0; stop_bits = 2'b01;
    f.data = 8'h81; f.par_en = 0; f.par_odd = 0; f.two_stop = 0; f.baud = BAUD;
    sb.push_back(f);
    valid = 1'b1;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL baud_zero_hold: %0d cycles not idle/unready, want 0", errs); end
    @(posedge clk); #1 baudrate = BAUD;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1 valid = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL baud_recover: ready=%0b want 1", ready); end
    wait_mon(ok);
    total++; if (!ok) begin bad++; $display("FAIL baud_recover_mon: monitor timeout, want idle"); end
  endtask

  initial begin : main
    test_reset;
    test_even_41;
    test_back_to_back;
    test_odd_ff;
    test_nopar_00;
    test_reset_mid;
    test_bad_baud;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d frames never sent, want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
